// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory-access stage (master) and the data memory (slave).
interface mem_access_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      input  dmem_gnt, dmem_rvalid, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      output dmem_gnt, dmem_rvalid, dmem_rdata
   );
endinterface

// File: rtl/mem_access_stage.sv
// RISC-V memory-access stage: turns LOAD/STORE into req/gnt/rvalid bus transactions, one writeback per instruction.
// Optional MEM_ALIGN_CHECK_EN: reject misaligned halfword/word accesses with mem_err instead of issuing them.
module mem_access_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [6:0]                 opcode,
   input  logic [2:0]                 funct3,
   input  logic [31:0]                alu_result,
   input  logic [31:0]                mem_addr,
   input  logic [31:0]                rs2_data,
   input  logic [4:0]                 rd,
   mem_access_stage_if.master         dmem,
   output logic                       wb_valid,
   output logic                       wb_we,
   output logic [4:0]                 wb_rd,
   output logic [31:0]                wb_data,
   output logic                       mem_err
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam int         CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   typedef struct packed {
      logic [2:0] funct3;
      logic [1:0] off;
      logic [4:0] rd;
   } acc_t;

   state_t        state;
   acc_t          acc;
   logic [CW-1:0] cnt;

   logic        is_load, is_store, f3_legal, misaligned, mem_ok, wr_op;
   logic [3:0]  be_c;
   logic [31:0] wdata_c;
   logic [31:0] shifted;
   logic [31:0] load_data;

   assign in_ready = (state == IDLE);

   always_comb begin
      is_load  = (opcode == OP_LOAD);
      is_store = (opcode == OP_STORE);
      f3_legal = 1'b0;
      if (is_load)
         f3_legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      else if (is_store)
         f3_legal = funct3 inside {3'b000, 3'b001, 3'b010};
`ifdef MEM_ALIGN_CHECK_EN
      misaligned = ((funct3[1:0] == 2'b01) && mem_addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (mem_addr[1:0] != 2'b00));
`else
      misaligned = 1'b0;
`endif
      mem_ok = (is_load || is_store) && f3_legal && !misaligned;
      wr_op  = opcode inside {7'b0110011, 7'b0010011, 7'b1101111,
                              7'b1100111, 7'b0110111, 7'b0010111};
   end

   // Lanes are shifted within a 4-bit field, so accesses crossing the word are truncated.
   always_comb begin
      be_c    = 4'hF << mem_addr[1:0];
      wdata_c = rs2_data;
      case (funct3[1:0])
         2'b00: begin
            be_c    = 4'b0001 << mem_addr[1:0];
            wdata_c = {4{rs2_data[7:0]}};
         end
         2'b01: begin
            be_c    = 4'b0011 << mem_addr[1:0];
            wdata_c = {2{rs2_data[15:0]}};
         end
         default: ;
      endcase
   end

   // Logical shift zero-fills lanes above the word before extension.
   always_comb begin
      shifted = dmem.dmem_rdata >> {acc.off, 3'b000};
      case (acc.funct3)
         3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  load_data = {24'h0, shifted[7:0]};
         3'b101:  load_data = {16'h0, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         acc             <= '0;
         cnt             <= '0;
         dmem.dmem_req   <= 1'b0;
         dmem.dmem_we    <= 1'b0;
         dmem.dmem_addr  <= '0;
         dmem.dmem_wdata <= '0;
         dmem.dmem_be    <= '0;
         wb_valid        <= 1'b0;
         wb_we           <= 1'b0;
         wb_rd           <= '0;
         wb_data         <= '0;
         mem_err         <= 1'b0;
      end else begin
         wb_valid <= 1'b0;
         wb_we    <= 1'b0;
         mem_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (mem_ok) begin
                     acc             <= '{funct3: funct3, off: mem_addr[1:0], rd: rd};
                     dmem.dmem_req   <= 1'b1;
                     dmem.dmem_we    <= is_store;
                     dmem.dmem_addr  <= {mem_addr[31:2], 2'b00};
                     dmem.dmem_be    <= be_c;
                     dmem.dmem_wdata <= is_store ? wdata_c : 32'h0;
                     state           <= REQ;
                  end else begin
                     // Rejected memory ops fall through here as non-memory ops with the error flag.
                     wb_valid <= 1'b1;
                     wb_rd    <= rd;
                     wb_data  <= alu_result;
                     wb_we    <= wr_op && (rd != 5'd0);
                     mem_err  <= is_load || is_store;
                  end
               end
            end
            REQ: begin
               if (dmem.dmem_gnt) begin
                  dmem.dmem_req <= 1'b0;
                  if (dmem.dmem_we) begin
                     wb_valid <= 1'b1;
                     wb_rd    <= acc.rd;
                     wb_data  <= '0;
                     state    <= IDLE;
                  end else begin
                     cnt   <= '0;
                     state <= RESP;
                  end
               end
            end
            RESP: begin
               if (dmem.dmem_rvalid) begin
                  wb_valid <= 1'b1;
                  wb_we    <= (acc.rd != 5'd0);
                  wb_rd    <= acc.rd;
                  wb_data  <= load_data;
                  state    <= IDLE;
               end else if (cnt == CNT_LAST) begin
                  wb_valid <= 1'b1;
                  wb_rd    <= acc.rd;
                  wb_data  <= '0;
                  mem_err  <= 1'b1;
                  state    <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected writebacks (with their cycle) are queued at stimulus time.
module tb_mem_access_stage;
   localparam int TIMEOUT = 16;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [6:0]  opcode = '0;
   logic [2:0]  funct3 = '0;
   logic [31:0] alu_result = '0, mem_addr = '0, rs2_data = '0;
   logic [4:0]  rd = '0;
   logic        wb_valid, wb_we, mem_err;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   mem_access_stage_if bus ();

   mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .funct3(funct3), .alu_result(alu_result), .mem_addr(mem_addr),
      .rs2_data(rs2_data), .rd(rd), .dmem(bus), .wb_valid(wb_valid), .wb_we(wb_we),
      .wb_rd(wb_rd), .wb_data(wb_data), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          at;
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        err;
      bit          chk_data;
   } exp_t;

   exp_t sb[$];
   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic push_exp(input int at, input logic we, input logic [4:0] r,
                           input logic [31:0] d, input logic err, input bit cd);
      exp_t e;
      e.at = at; e.we = we; e.rd = r; e.data = d; e.err = err; e.chk_data = cd;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (wb_valid) begin
            if (sb.size() == 0) chk("unexpected_wb", 1, 0);
            else begin
               e = sb.pop_front();
               chk("wb_cycle", cyc, e.at);
               chk("wb_we", wb_we, e.we);
               chk("wb_rd", wb_rd, e.rd);
               chk("mem_err", mem_err, e.err);
               if (e.chk_data) chk("wb_data", wb_data, e.data);
            end
         end else if (wb_we || mem_err) begin
            chk("pulse_without_valid", {wb_we, mem_err}, 2'b00);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] a, input logic [31:0] s, input logic [4:0] r);
      chk("in_ready_before", in_ready, 1);
      opcode = op; funct3 = f3; alu_result = alu; mem_addr = a; rs2_data = s; rd = r;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic run_nonmem(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] alu,
                             input logic [31:0] a, input logic [4:0] r,
                             input logic exp_we, input logic exp_err);
      push_exp(cyc + 1, exp_we, r, alu, exp_err, 1'b1);
      send(op, f3, alu, a, 32'h0, r);
      chk("no_bus_req", bus.dmem_req, 0);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (!in_ready && n < 40) begin
         tick();
         n++;
      end
      if (!in_ready) chk(tag, 0, 1);
   endtask

   task automatic run_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] s,
                            input logic [4:0] r, input int gnt_dly, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd);
      send(OP_STORE, f3, 32'h0, a, s, r);
      chk("st_req", bus.dmem_req, 1);
      chk("st_we", bus.dmem_we, 1);
      chk("st_addr", bus.dmem_addr, exp_addr);
      chk("st_be", bus.dmem_be, exp_be);
      chk("st_wdata", bus.dmem_wdata, exp_wd);
      repeat (gnt_dly) begin
         tick();
         chk("st_hold", {bus.dmem_req, bus.dmem_be}, {1'b1, exp_be});
      end
      bus.dmem_gnt = 1'b1;
      push_exp(cyc + 1, 1'b0, r, 32'h0, 1'b0, 1'b0);
      tick();
      bus.dmem_gnt = 1'b0;
      chk("st_req_drop", bus.dmem_req, 0);
   endtask

   task automatic run_load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] r,
                           input int gnt_dly, input logic [31:0] rdata, input int rv_dly,
                           input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic [31:0] exp_data);
      send(OP_LOAD, f3, 32'h0, a, 32'h0, r);
      chk("ld_req", bus.dmem_req, 1);
      chk("ld_we", bus.dmem_we, 0);
      chk("ld_addr", bus.dmem_addr, exp_addr);
      chk("ld_be", bus.dmem_be, exp_be);
      repeat (gnt_dly) tick();
      bus.dmem_gnt = 1'b1;
      if (rv_dly < 0) push_exp(cyc + TIMEOUT + 1, 1'b0, r, 32'h0, 1'b1, 1'b0);
      tick();
      bus.dmem_gnt = 1'b0;
      chk("ld_req_drop", bus.dmem_req, 0);
      if (rv_dly >= 0) begin
         repeat (rv_dly) tick();
         bus.dmem_rdata = rdata;
         bus.dmem_rvalid = 1'b1;
         push_exp(cyc + 1, r != 5'd0, r, exp_data, 1'b0, 1'b1);
         tick();
         bus.dmem_rvalid = 1'b0;
         bus.dmem_rdata = 32'h0;
      end else begin
         wait_idle("timeout_wait");
         chk("in_ready_after_to", in_ready, 1);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.dmem_gnt = 1'b0;
      bus.dmem_rvalid = 1'b0;
      bus.dmem_rdata = 32'h0;
      repeat (3) tick();
      chk("rst_req", bus.dmem_req, 0);
      chk("rst_wb", {wb_valid, wb_we, mem_err, bus.dmem_we, bus.dmem_be}, 0);
      chk("rst_data", wb_data | bus.dmem_addr | bus.dmem_wdata | 32'(wb_rd), 0);
      chk("rst_in_ready", in_ready, 1);
      rst_n = 1'b1;
      tick();

      // Non-memory ops, back to back
      run_nonmem(7'b0010011, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0);
      run_nonmem(7'b0010011, 3'b000, 32'h1234, 32'h0, 5'd0, 1'b0, 1'b0);
      run_nonmem(7'b1100011, 3'b001, 32'hCAFE, 32'h0, 5'd3, 1'b0, 1'b0);
      run_nonmem(7'b0110111, 3'b000, 32'hABCD0000, 32'h0, 5'd9, 1'b1, 1'b0);
      run_nonmem(7'b1111111, 3'b000, 32'h55, 32'h0, 5'd4, 1'b0, 1'b0);
      run_nonmem(7'b1101111, 3'b000, 32'h104, 32'h0, 5'd1, 1'b1, 1'b0);

      // Stores
      run_store(3'b000, 32'h1003, 32'hAABBCCDD, 5'd2, 2, 32'h1000, 4'b1000, 32'hDDDDDDDD);
      run_store(3'b001, 32'h1002, 32'h12345678, 5'd6, 0, 32'h1000, 4'b1100, 32'h56785678);
      run_store(3'b010, 32'h1004, 32'h0BADF00D, 5'd7, 1, 32'h1004, 4'b1111, 32'h0BADF00D);

      // Loads
      run_load(3'b000, 32'h2001, 5'd8, 0, 32'h000080FF, 0, 32'h2000, 4'b0010, 32'hFFFFFF80);
      run_load(3'b100, 32'h2001, 5'd8, 1, 32'h000080FF, 2, 32'h2000, 4'b0010, 32'h00000080);
      run_load(3'b101, 32'h2002, 5'd10, 0, 32'h80010000, 1, 32'h2000, 4'b1100, 32'h00008001);
      run_load(3'b001, 32'h2002, 5'd11, 0, 32'h80010000, 0, 32'h2000, 4'b1100, 32'hFFFF8001);
      run_load(3'b010, 32'h2000, 5'd0, 0, 32'hDEADBEEF, 0, 32'h2000, 4'b1111, 32'hDEADBEEF);

      // Timeout, then illegal funct3
      run_load(3'b010, 32'h2004, 5'd12, 1, 32'h0, -1, 32'h2004, 4'b1111, 32'h0);
      run_nonmem(OP_LOAD, 3'b011, 32'h77, 32'h2000, 5'd13, 1'b0, 1'b1);
      run_nonmem(OP_STORE, 3'b011, 32'h88, 32'h2000, 5'd14, 1'b0, 1'b1);

`ifdef MEM_ALIGN_CHECK_EN
      run_nonmem(OP_LOAD, 3'b010, 32'h99, 32'h3002, 5'd15, 1'b0, 1'b1);
`else
      run_load(3'b010, 32'h3002, 5'd15, 0, 32'h11223344, 0, 32'h3000, 4'b1100, 32'h00001122);
`endif

      // Reset in the middle of a load response; late rvalid must be dropped
      send(OP_LOAD, 3'b010, 32'h0, 32'h4000, 32'h0, 5'd7);
      bus.dmem_gnt = 1'b1;
      tick();
      bus.dmem_gnt = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_ctrl", {wb_valid, wb_we, mem_err, bus.dmem_req, bus.dmem_we, bus.dmem_be}, 0);
      chk("midrst_data", wb_data | bus.dmem_addr | bus.dmem_wdata | 32'(wb_rd), 0);
      tick();
      rst_n = 1'b1;
      bus.dmem_rdata = 32'h12345678;
      bus.dmem_rvalid = 1'b1;
      tick();
      bus.dmem_rvalid = 1'b0;
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_no_wb", wb_valid, 0);
      repeat (3) tick();
      chk("post_rst_idle", {wb_valid, bus.dmem_req}, 0);
      chk("sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the RISC-V pipeline, directly downstream of the execute stage. It accepts one executed instruction at a time: ALU result, memory address, store data, destination register, opcode and funct3. LOAD and STORE instructions are turned into a request/grant/response transaction on the data-memory bus. Every instruction produces exactly one registered writeback result.

## Interface
Parameters:
- TIMEOUT, 16: max cycles waiting for dmem_rvalid after grant before a load is aborted with an error.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  execute result valid
- in_ready  out  1  stage can accept; equals (state==IDLE)
- opcode  in  7  instruction opcode
- funct3  in  3  access size/sign
- alu_result  in  32  execute ALU result
- mem_addr  in  32  effective address (LOAD/STORE)
- rs2_data  in  32  store data
- rd  in  5  destination register
- dmem_req  out  1  bus request
- dmem_we  out  1  1=store
- dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load data word
- wb_valid  out  1  one-cycle result pulse
- wb_we  out  1  register write enable
- wb_rd  out  5  destination register
- wb_data  out  32  writeback data
- mem_err  out  1  misaligned / illegal funct3 / timeout, valid with wb_valid

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE, accept (in_valid&in_ready), non-memory opcode: next cycle wb_valid=1, wb_data=alu_result, wb_rd=rd. wb_we=1 iff rd!=0 and opcode ∈ {0110011, 0010011, 1101111, 1100111, 0110111, 0010111}. Branches (1100011) and unknown opcodes give wb_we=0. Stay IDLE.
- IDLE, accept, LOAD (0000011) or STORE (0100011): latch the access fields and go to REQ. Exception: an illegal or misaligned access (see Configuration) does not go to REQ; it behaves like a non-memory op with wb_we=0, mem_err=1, and no bus activity.
- Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. Any other funct3 is illegal.
- Store lanes: SB gives be=1<<a[1:0] and wdata={4{rs2[7:0]}}. SH gives be=2'b11<<a[1:0] truncated to 4 bits and wdata={2{rs2[15:0]}}. SW gives be=4'hF and wdata=rs2.
- REQ: dmem_req=1 with address, we, be and wdata held stable until dmem_gnt.
  - Grant on a store: go to IDLE; wb_valid pulses next cycle with wb_we=0.
  - Grant on a load: go to RESP and clear the timeout counter.
- RESP: dmem_req=0.
  - On dmem_rvalid: select the byte or halfword at a[1:0] and sign- or zero-extend per funct3. Next cycle wb_valid=1, wb_we=(rd!=0), go to IDLE.
  - The counter increments each cycle without rvalid. When it reaches TIMEOUT: go to IDLE; wb_valid=1, wb_we=0, mem_err=1.
- dmem_rvalid outside RESP is ignored. dmem_gnt outside REQ is ignored.
- Reset, at any time including mid-transaction: state=IDLE. dmem_req, dmem_we, dmem_be, wb_valid, wb_we and mem_err go to 0; all data/address outputs and wb_rd go to 0; the counter goes to 0. A response arriving after reset is dropped.

## Timing
- All outputs are registered except in_ready, which is decoded from state.
- Non-memory latency: 1 cycle (accept at cycle N, wb_valid at N+1).
- Store: dmem_req rises at N+1. With gnt at cycle G, wb_valid is at G+1. Minimum latency is 2.
- Load: gnt at G, rvalid at R≥G+1, wb_valid at R+1. Minimum latency is 3.
- Timeout: wb_valid/mem_err at G+TIMEOUT+1 if no rvalid arrives.
- wb_valid, wb_we and mem_err are high for exactly one cycle per instruction. in_ready is high again in the cycle wb_valid pulses, so back-to-back non-memory ops sustain 1 per cycle.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - LH/LHU/SH with a[0]=1 are misaligned.
  - LW/SW with a[1:0]!=0 are misaligned.
  - A misaligned access is reported with mem_err=1 and wb_we=0, and issues no bus request.
- MEM_ALIGN_CHECK_EN undefined: no alignment check.
  - The access is issued to the word-aligned address. Lanes are truncated at the word boundary (SH at offset 3 gives be=4'b1000).
  - A load reads the truncated lanes, zero-filled above the word before extension.
  - mem_err then flags only illegal funct3 and timeout.

## Test plan
- Reset asserted mid-RESP with rvalid arriving one cycle later -> all outputs 0, no wb_valid, in_ready=1 after release.
- ADDI: opcode 0010011, rd=5, alu_result=0x1234 -> next cycle wb_valid=1, wb_we=1, wb_rd=5, wb_data=0x00001234. The same op with rd=0 gives wb_we=0.
- SB: addr 0x1003, rs2=0xAABBCCDD, gnt after 2 cycles -> dmem_addr=0x1000, be=4'b1000, wdata=0xDDDDDDDD, dmem_we=1; wb_valid 1 cycle after gnt with wb_we=0.
- LB, addr 0x2001, rdata=0x0000_80FF -> wb_data=0xFFFFFF80. LBU on the same data gives 0x00000080. LHU at 0x2002 with rdata=0x8001_0000 gives 0x00008001.
- LW with gnt but no rvalid, TIMEOUT=16 -> wb_valid and mem_err at gnt+17, wb_we=0, in_ready back to 1.
- With MEM_ALIGN_CHECK_EN: LW at 0x3002 -> dmem_req never asserted; wb_valid=1 and mem_err=1 the next cycle. Without the macro: dmem_addr=0x3000 and be=4'b1100.
